// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encodings common to the requester and completer.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

endpackage

// File: rtl/apb_tx.sv
// APB requester: turns valid/ready read/write commands into APB SETUP/ACCESS
// transfers and returns a one-cycle response pulse, with a pready timeout.
module apb_tx
  import apb_pkg::*;
#(
  parameter int unsigned DATA_BW = 8,
  parameter int unsigned ADDR_BW = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_write,
  input  logic [ADDR_BW-1:0] cmd_addr,
  input  logic [DATA_BW-1:0] cmd_wdata,
  output logic               rsp_valid,
  output logic [DATA_BW-1:0] rsp_rdata,
  output logic               rsp_err,
  output logic               psel,
  output logic               penable,
  output logic               pwrite,
  output logic [ADDR_BW-1:0] paddr,
  output logic [DATA_BW-1:0] pwdata,
  input  logic [DATA_BW-1:0] prdata,
  input  logic               pready
);

  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  apb_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               psel_d, penable_d, pwrite_d;
  logic [ADDR_BW-1:0] paddr_d;
  logic [DATA_BW-1:0] pwdata_d;
  logic               rsp_valid_d, rsp_err_d;
  logic [DATA_BW-1:0] rsp_rdata_d;
  logic               load;
  logic               timeout_hit;

  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    psel_d      = psel;
    penable_d   = penable;
    pwrite_d    = pwrite;
    paddr_d     = paddr;
    pwdata_d    = pwdata;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata;
    rsp_err_d   = rsp_err;
    cmd_ready   = 1'b0;
    load        = 1'b0;

    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        load      = cmd_valid;
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end
      ACCESS: begin
        if (pready) begin
          cmd_ready   = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = pwrite ? '0 : prdata;
          state_d     = IDLE;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          load        = cmd_valid;
        end else if (timeout_hit) begin
          // Abort a hung slave; counter holds until the next SETUP.
          state_d     = IDLE;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d   = IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase

    // Accepted command overrides the completion path and starts SETUP.
    if (load) begin
      state_d   = SETUP;
      psel_d    = 1'b1;
      penable_d = 1'b0;
      pwrite_d  = cmd_write;
      paddr_d   = cmd_addr;
      pwdata_d  = cmd_wdata;
      cnt_d     = '0;
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      psel      <= psel_d;
      penable   <= penable_d;
      pwrite    <= pwrite_d;
      paddr     <= paddr_d;
      pwdata    <= pwdata_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
      rsp_err   <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_apb_tx.sv
// Bench for apb_tx against a behavioural APB memory slave with programmable
// wait states and a stuck-pready mode; responses checked through a scoreboard.
module tb_apb_tx;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid, cmd_ready, cmd_write;
  logic [7:0] cmd_addr, cmd_wdata;
  logic       rsp_valid, rsp_err;
  logic [7:0] rsp_rdata;
  logic       psel, penable, pwrite;
  logic [7:0] paddr, pwdata, prdata;
  logic       pready;

  apb_tx #(.DATA_BW(8), .ADDR_BW(8), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata), .pready(pready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave model: memory, wait-state counter, stuck-pready switch
  logic [7:0] mem [256];
  int         wait_cfg;
  int         wait_left;
  logic       hang;

  assign prdata = mem[paddr];
  assign pready = !hang && (wait_left == 0);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) wait_left <= 0;
    else if (psel && !penable) wait_left <= wait_cfg;
    else if (psel && penable && wait_left != 0) wait_left <= wait_left - 1;
  end

  always @(posedge clk) begin
    if (rst_n && psel && penable && pready && pwrite) mem[paddr] <= pwdata;
  end

  typedef struct packed {
    logic [7:0] rdata;
    logic       err;
  } exp_t;

  typedef struct packed {
    logic       psel;
    logic       penable;
    logic [7:0] paddr;
    logic [7:0] pwdata;
    logic       rsp_valid;
  } trace_t;

  exp_t   exp_q[$];
  trace_t trace[$];
  logic   [7:0] exp_mem [256];
  logic   log_en;
  int     checks;
  int     errors;

  // Scoreboard consumer and optional bus trace, sampled on the falling edge
  task automatic run_monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (log_en) trace.push_back({psel, penable, paddr, pwdata, rsp_valid});
      if (rsp_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_rsp: rdata=%h err=%b with nothing outstanding", rsp_rdata, rsp_err);
        end else begin
          e = exp_q.pop_front();
          if ({rsp_rdata, rsp_err} !== {e.rdata, e.err}) begin
            errors++;
            $display("FAIL rsp_data: got rdata=%h err=%b, expected rdata=%h err=%b",
                     rsp_rdata, rsp_err, e.rdata, e.err);
          end
        end
      end
    end
  endtask

  // Present a command, wait for the handshake, push the expected response
  task automatic send(input logic w, input logic [7:0] a, input logic [7:0] d, input logic err_exp);
    int   n;
    exp_t e;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL send_timeout: cmd_ready=%b, expected 1 within 200 cycles", cmd_ready);
      cmd_valid = 1'b0;
      return;
    end
    e.err   = err_exp;
    e.rdata = (w || err_exp) ? 8'h00 : exp_mem[a];
    if (w && !err_exp) exp_mem[a] = d;
    exp_q.push_back(e);
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_err} !== 30'd0) begin
      errors++;
      $display("FAIL reset_outputs: psel=%b pen=%b pwr=%b paddr=%h pwdata=%h rv=%b rd=%h re=%b, expected all 0",
               psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_err);
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: cmd_ready=%b, expected 1", cmd_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_write_latency();
    send(1'b1, 8'h10, 8'h5A, 1'b0);
    @(negedge clk); cmd_valid = 1'b0;
    checks++;
    if ({psel, penable} !== 2'b10) begin
      errors++; $display("FAIL lat_setup: psel/penable=%b%b, expected 10", psel, penable);
    end
    @(negedge clk);
    checks++;
    if ({psel, penable} !== 2'b11) begin
      errors++; $display("FAIL lat_access: psel/penable=%b%b, expected 11", psel, penable);
    end
    @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_err, psel} !== 3'b100) begin
      errors++; $display("FAIL lat_rsp: rsp_valid=%b rsp_err=%b psel=%b, expected 1 0 0", rsp_valid, rsp_err, psel);
    end
    checks++;
    if (mem[8'h10] !== 8'h5A) begin
      errors++; $display("FAIL write_mem: mem[10]=%h, expected 5a", mem[8'h10]);
    end
    idle(2);
  endtask

  task automatic test_read();
    send(1'b0, 8'h10, 8'h00, 1'b0);
    idle(4);
  endtask

  task automatic test_back_to_back();
    int         first;
    int         pulses;
    logic [7:0] pat;
    trace.delete();
    log_en = 1'b1;
    send(1'b1, 8'h50, 8'h11, 1'b0);
    send(1'b1, 8'h51, 8'h22, 1'b0);
    idle(6);
    log_en = 1'b0;
    first = -1; pulses = 0; pat = 8'h00;
    foreach (trace[i]) begin
      if (trace[i].psel && first < 0) first = i;
      if (trace[i].rsp_valid) pulses++;
    end
    checks++;
    if (first < 0 || first + 4 >= trace.size()) begin
      errors++; $display("FAIL b2b_trace: psel start index %0d in %0d samples", first, trace.size());
    end else begin
      for (int k = 0; k < 4; k++) pat = {pat[5:0], trace[first+k].psel, trace[first+k].penable};
      checks++;
      if (pat !== 8'b10111011) begin
        errors++; $display("FAIL b2b_phases: psel/penable seq=%b, expected 10111011", pat);
      end
      checks++;
      if (trace[first+4].psel !== 1'b0) begin
        errors++; $display("FAIL b2b_release: psel=%b after two transfers, expected 0", trace[first+4].psel);
      end
    end
    checks++;
    if (pulses != 2) begin
      errors++; $display("FAIL b2b_pulses: %0d rsp pulses, expected 2", pulses);
    end
    send(1'b0, 8'h51, 8'h00, 1'b0);
    idle(4);
  endtask

  task automatic test_wait_states();
    int   acc;
    int   last;
    logic stable;
    wait_cfg = 3;
    trace.delete();
    log_en = 1'b1;
    send(1'b1, 8'h22, 8'hC3, 1'b0);
    idle(8);
    log_en = 1'b0;
    wait_cfg = 0;
    acc = 0; last = -1; stable = 1'b1;
    foreach (trace[i]) begin
      if (trace[i].psel && trace[i].penable) begin
        acc++; last = i;
        if (trace[i].paddr !== 8'h22 || trace[i].pwdata !== 8'hC3) stable = 1'b0;
      end
    end
    checks++;
    if (acc != 4) begin
      errors++; $display("FAIL wait_access: %0d ACCESS cycles, expected 4", acc);
    end
    checks++;
    if (!stable) begin
      errors++; $display("FAIL wait_stable: paddr/pwdata changed during ACCESS, expected 22/c3 held");
    end
    checks++;
    if (last < 0 || last + 1 >= trace.size() || trace[last+1].rsp_valid !== 1'b1) begin
      errors++; $display("FAIL wait_rsp: no rsp_valid the cycle after pready (last ACCESS index %0d)", last);
    end
    send(1'b0, 8'h22, 8'h00, 1'b0);
    idle(4);
  endtask

  task automatic test_timeout();
    int acc;
    int last;
    hang = 1'b1;
    trace.delete();
    log_en = 1'b1;
    send(1'b0, 8'h10, 8'h00, 1'b1);
    idle(24);
    log_en = 1'b0;
    hang = 1'b0;
    acc = 0; last = -1;
    foreach (trace[i]) begin
      if (trace[i].psel && trace[i].penable) begin
        acc++; last = i;
      end
    end
    checks++;
    if (acc != 16) begin
      errors++; $display("FAIL timeout_cycles: %0d ACCESS cycles before abort, expected 16", acc);
    end
    checks++;
    if (last < 0 || last + 1 >= trace.size() ||
        {trace[last+1].psel, trace[last+1].rsp_valid} !== 2'b01) begin
      errors++; $display("FAIL timeout_abort: psel not dropped with rsp pulse after last ACCESS (index %0d)", last);
    end
    checks++;
    if ({rsp_err, rsp_rdata} !== 9'h100) begin
      errors++; $display("FAIL timeout_hold: rsp_err=%b rsp_rdata=%h, expected held 1/00", rsp_err, rsp_rdata);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] old;
    old = exp_mem[8'h40];
    wait_cfg = 5;
    send(1'b1, 8'h40, 8'h77, 1'b0);
    @(negedge clk); cmd_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({psel, penable} !== 2'b11) begin
      errors++; $display("FAIL rst_pre: psel/penable=%b%b, expected 11", psel, penable);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({psel, penable, rsp_valid} !== 3'b000) begin
      errors++; $display("FAIL rst_drop: psel=%b penable=%b rsp_valid=%b, expected 0 0 0", psel, penable, rsp_valid);
    end
    void'(exp_q.pop_back());
    exp_mem[8'h40] = old;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_cfg = 0;
    repeat (4) @(negedge clk);
    checks++;
    if (mem[8'h40] !== old) begin
      errors++; $display("FAIL rst_nowrite: mem[40]=%h, expected %h", mem[8'h40], old);
    end
    send(1'b1, 8'h40, 8'h99, 1'b0);
    send(1'b0, 8'h40, 8'h00, 1'b0);
    idle(4);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 8'h00; cmd_wdata = 8'h00;
    hang = 1'b0; wait_cfg = 0; log_en = 1'b0; checks = 0; errors = 0;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'h00;
      exp_mem[i] = 8'h00;
    end
    fork
      run_monitor();
    join_none

    test_reset();
    test_write_latency();
    test_read();
    test_back_to_back();
    test_wait_states();
    test_timeout();
    test_reset_mid();

    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL drain: %0d responses outstanding, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
